// File: rtl/cnn_pkg.sv
// cnn_pkg: shared geometry constants and feeder state encoding
package cnn_pkg;
  localparam int IMG_W = 28;
  localparam int WIN = 5;
  localparam int PIX_W = 8;
  localparam int OUT_DIM = IMG_W - WIN + 1;
  localparam int NPIX = IMG_W * IMG_W;
  typedef enum logic [2:0] {S_LOAD, S_START, S_SWEEP, S_WAIT, S_RESULT} state_t;
endpackage

// File: rtl/cnn_frame_buf.sv
// cnn_frame_buf: raster frame store with one write port and a combinational WINxWIN window read
module cnn_frame_buf #(
  parameter int IMG_W = cnn_pkg::IMG_W,
  parameter int WIN = cnn_pkg::WIN,
  parameter int PIX_W = cnn_pkg::PIX_W,
  localparam int AW = $clog2(IMG_W * IMG_W),
  localparam int CW = $clog2(IMG_W - WIN + 1)
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [PIX_W-1:0]         wdata_i,
  input  logic [CW-1:0]            x_i,
  input  logic [CW-1:0]            y_i,
  output logic [WIN*WIN*PIX_W-1:0] win_o
);
  logic [PIX_W-1:0] mem_q [IMG_W*IMG_W];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // Window pixel (r,c) lands MSB-first: row 0 col 0 occupies the top byte
  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < WIN; c++) begin : g_col
      logic [AW-1:0] a;
      assign a = AW'((int'(y_i) + r) * IMG_W + int'(x_i) + c);
      assign win_o[(WIN*WIN-1-r*WIN-c)*PIX_W +: PIX_W] = mem_q[a];
    end
  end
endmodule

// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: loads a raster frame, sweeps every WINxWIN window to a CNN, captures its label
module cnn_window_feeder #(
  parameter int IMG_W = 28,
  parameter int WIN = 5,
  parameter int PIX_W = 8,
  localparam int CW = $clog2(IMG_W - WIN + 1),
  localparam int AW = $clog2(IMG_W * IMG_W)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     PIX_VALID,
  input  logic [PIX_W-1:0]         PIX_DATA,
  output logic                     PIX_READY,
  output logic                     START,
  output logic [CW-1:0]            X,
  output logic [CW-1:0]            Y,
  output logic                     WIN_VALID,
  output logic [WIN*WIN*PIX_W-1:0] IMGIN,
  input  logic                     DONE,
  input  logic [3:0]               OUT,
  output logic                     RES_VALID,
  output logic [3:0]               RES_LABEL,
  output logic                     BUSY
);
  import cnn_pkg::*;
  localparam logic [CW-1:0] LAST = CW'(IMG_W - WIN);
  localparam logic [AW-1:0] NLAST = AW'(IMG_W * IMG_W - 1);
  state_t state_q;
  logic [AW-1:0] cnt_q;
  logic [CW-1:0] x_q, y_q;
  logic [3:0] label_q;
  logic [WIN*WIN*PIX_W-1:0] win;
  logic we;
  assign we = PIX_VALID && state_q == S_LOAD;
  cnn_frame_buf #(.IMG_W(IMG_W), .WIN(WIN), .PIX_W(PIX_W)) u_buf (
    .clk(CLK), .we_i(we), .waddr_i(cnt_q), .wdata_i(PIX_DATA),
    .x_i(x_q), .y_i(y_q), .win_o(win)
  );
  always_ff @(posedge CLK)
    if (!nRST) begin
      state_q <= S_LOAD;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      label_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: if (we) begin
          cnt_q <= cnt_q == NLAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == NLAST) state_q <= S_START;
        end
        S_START: state_q <= S_SWEEP;
        S_SWEEP: begin
          // Y is the inner index; X advances on the same cycle Y wraps
          y_q <= y_q == LAST ? '0 : y_q + 1'b1;
          if (y_q == LAST) begin
            x_q <= x_q == LAST ? '0 : x_q + 1'b1;
            if (x_q == LAST) state_q <= S_WAIT;
          end
        end
        S_WAIT: if (DONE) begin
          label_q <= OUT;
          state_q <= S_RESULT;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  assign PIX_READY = state_q == S_LOAD;
  assign START = state_q == S_START;
  assign WIN_VALID = state_q == S_SWEEP;
  assign RES_VALID = state_q == S_RESULT;
  assign BUSY = state_q != S_LOAD;
  assign X = x_q;
  assign Y = y_q;
  assign RES_LABEL = label_q;
  assign IMGIN = WIN_VALID ? win : '0;
endmodule

// File: tb/tb_cnn_window_feeder.sv
// tb_cnn_window_feeder: directed sequence with random frames against an image-array reference model
module tb_cnn_window_feeder;
  localparam int N = 28, W = 5, OD = N - W + 1, NP = N * N;
  logic CLK = 1'b0, nRST = 1'b0, PIX_VALID = 1'b0, DONE = 1'b0;
  logic [7:0] PIX_DATA = '0;
  logic [3:0] OUT = '0;
  logic PIX_READY, START, WIN_VALID, RES_VALID, BUSY;
  logic [4:0] X, Y;
  logic [199:0] IMGIN;
  logic [3:0] RES_LABEL;
  logic [7:0] img [N][N];
  logic [3:0] prev_lab = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  cnn_window_feeder dut (
    .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY), .START(START), .X(X), .Y(Y), .WIN_VALID(WIN_VALID),
    .IMGIN(IMGIN), .DONE(DONE), .OUT(OUT), .RES_VALID(RES_VALID),
    .RES_LABEL(RES_LABEL), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [199:0] win_of(input int x, input int y);
    logic [199:0] w = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        w[199-40*r-8*c -: 8] = img[y+r][x+c];
    return w;
  endfunction

  task automatic fill(input bit ramp);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = ramp ? 8'((r * N + c) % 256) : 8'($urandom);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 256'({X, Y, START, WIN_VALID, IMGIN, RES_VALID, RES_LABEL, BUSY, PIX_READY}), 256'd1);
  endtask

  task automatic load_frame(input int mode);
    int k = 0, cyc = 0, early = 0;
    logic v;
    while (k < NP && cyc < 5000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      PIX_VALID = v;
      PIX_DATA = v ? img[k/N][k%N] : 8'($urandom);
      DONE = 1'($urandom_range(0, 1));
      OUT = 4'($urandom);
      tick;
      cyc++;
      if (v) k++;
      if (k < NP && (START || BUSY || !PIX_READY)) early++;
    end
    PIX_VALID = 1'b0;
    DONE = 1'b0;
    chk("load_ready", 256'(early), 256'd0);
    chk("load_count", 256'(k), 256'(NP));
    chk("start_pulse", 256'({START, BUSY, PIX_READY, WIN_VALID, X, Y, IMGIN}),
        256'({4'b1100, 10'd0, 200'd0}));
  endtask

  task automatic sweep(input bit hold, input bit ramp, input int stop_at);
    DONE = 1'b1;
    for (int i = 0; i < OD * OD; i++) begin
      OUT = 4'($urandom);
      if (hold) begin
        PIX_VALID = 1'b1;
        PIX_DATA = 8'($urandom);
      end
      tick;
      chk($sformatf("win%0d", i), 256'({START, BUSY, WIN_VALID, X, Y, IMGIN}),
          256'({1'b0, 1'b1, 1'b1, 5'(i / OD), 5'(i % OD), win_of(i / OD, i % OD)}));
      if (ramp && i == 0) begin
        chk("ramp00_top", 256'(IMGIN[199:192]), 256'h00);
        chk("ramp00_bot", 256'(IMGIN[7:0]), 256'h74);
      end
      if (ramp && i == OD * OD - 1) begin
        chk("ramp2323_top", 256'(IMGIN[199:192]), 256'h9b);
        chk("ramp2323_bot", 256'(IMGIN[7:0]), 256'h0f);
      end
      if (i == stop_at) return;
    end
  endtask

  task automatic finish_frame(input logic [3:0] lab);
    tick;
    DONE = 1'b0;
    chk("wait_entry", 256'({START, WIN_VALID, X, Y, IMGIN, BUSY, RES_VALID, PIX_READY, RES_LABEL}),
        256'({1'b0, 1'b0, 10'd0, 200'd0, 1'b1, 1'b0, 1'b0, prev_lab}));
    PIX_VALID = 1'b1;
    repeat (7) tick;
    chk("wait_hold", 256'({BUSY, RES_VALID, PIX_READY, RES_LABEL}), 256'({3'b100, prev_lab}));
    DONE = 1'b1;
    OUT = lab;
    tick;
    DONE = 1'b0;
    OUT = ~lab;
    chk("result", 256'({RES_VALID, RES_LABEL, BUSY, PIX_READY, WIN_VALID}), 256'({1'b1, lab, 3'b100}));
    tick;
    PIX_VALID = 1'b0;
    chk("back_load", 256'({RES_VALID, RES_LABEL, BUSY, PIX_READY, START}), 256'({1'b0, lab, 3'b010}));
    prev_lab = lab;
  endtask

  initial begin
    repeat (2) tick;
    chk_reset("rst_power");
    nRST = 1'b1;
    // partial load interrupted by reset must restart the pixel count
    PIX_VALID = 1'b1;
    repeat (100) begin
      PIX_DATA = 8'($urandom);
      DONE = 1'($urandom_range(0, 1));
      tick;
    end
    nRST = 1'b0;
    tick;
    PIX_VALID = 1'b0;
    DONE = 1'b0;
    chk_reset("rst_midload");
    nRST = 1'b1;
    fill(1'b1);
    load_frame(0);
    sweep(1'b0, 1'b1, -1);
    finish_frame(4'd7);
    load_frame(1);
    sweep(1'b1, 1'b1, -1);
    finish_frame(4'($urandom));
    fill(1'b0);
    load_frame(2);
    sweep(1'b1, 1'b0, 10 * OD + 5);
    nRST = 1'b0;
    DONE = 1'b0;
    PIX_VALID = 1'b0;
    tick;
    chk_reset("rst_midsweep");
    nRST = 1'b1;
    prev_lab = '0;
    fill(1'b1);
    load_frame(2);
    sweep(1'b0, 1'b1, -1);
    finish_frame(4'($urandom));
    fill(1'b0);
    load_frame(0);
    sweep(1'b1, 1'b0, -1);
    finish_frame(4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnn_window_feeder.md
CNN_WINDOW_FEEDER -- requirements
Module: cnn_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width and height in pixels.
REQ-002 SHALL have parameter WIN, default 5, convolution window edge in pixels.
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have ports:
  - CLK  in  1  clock; one clock, all logic on rising edge.
  - nRST  in  1  reset; synchronous, active-low.
  - PIX_VALID  in  1  raster pixel offered.
  - PIX_DATA  in  8  pixel value; raster order, row 0 col 0 first.
  - PIX_READY  out  1  feeder accepts pixel this cycle.
  - START  out  1  one-cycle pulse to CNN before the window sweep.
  - X  out  5  window column origin.
  - Y  out  5  window row origin.
  - WIN_VALID  out  1  IMGIN/X/Y carry a valid window.
  - IMGIN  out  200  5x5 window, 25 pixels of 8 bits.
  - DONE  in  1  CNN result ready.
  - OUT  in  4  CNN class label.
  - RES_VALID  out  1  one-cycle pulse, label captured.
  - RES_LABEL  out  4  captured label.
  - BUSY  out  1  high in any state except LOAD.

Function
REQ-005 SHALL implement FSM states LOAD, START, SWEEP, WAIT, RESULT.
REQ-006 SHALL drive PIX_READY=1 only in LOAD; a pixel is accepted when PIX_VALID&&PIX_READY and written at raster address row*28+col.
REQ-007 SHALL ignore PIX_VALID in every state other than LOAD.
REQ-008 SHALL go LOAD->START in the cycle after the 784th pixel is accepted; PIX_VALID gaps only stall the count.
REQ-009 SHALL assert START for exactly one cycle in state START, with X=0, Y=0, WIN_VALID=0.
REQ-010 SHALL enter SWEEP the cycle after START and present exactly 576 windows, one per cycle, with WIN_VALID=1.
REQ-011 SHALL order the sweep X-outer, Y-inner: (0,0),(0,1)..(0,23),(1,0)..(23,23); Y wraps 23->0 and X increments in the same cycle.
REQ-012 SHALL pack IMGIN so that bits [199-40r -: 40] hold window row r (image row Y+r), and within that row byte c (MSB first) is pixel(Y+r, X+c), for r,c in 0..4.
REQ-013 SHALL derive IMGIN combinationally from the registered X/Y and the buffer, with zero latency, and force IMGIN=0 whenever WIN_VALID=0.
REQ-014 SHALL go SWEEP->WAIT after window (23,23); X and Y return to 0.
REQ-015 SHALL ignore DONE in LOAD, START and SWEEP.
REQ-016 SHALL, in WAIT on DONE=1, register OUT into RES_LABEL and go to RESULT.
REQ-017 SHALL pulse RES_VALID for one cycle in RESULT, then return to LOAD; RES_LABEL SHALL hold until the next capture.
REQ-018 SHALL wait in WAIT indefinitely; there is no timeout.

Reset
REQ-019 SHALL on nRST=0 at a rising edge, in any state including mid-load and mid-sweep, enter LOAD with pixel count 0.
REQ-020 SHALL reset outputs to: X=0, Y=0, START=0, WIN_VALID=0, IMGIN=0, RES_VALID=0, RES_LABEL=0, BUSY=0, PIX_READY=1 on the first cycle after reset.
REQ-021 SHALL not reset frame buffer contents; they are invisible until a full reload, per REQ-013.

Structure
REQ-022 SHALL place IMG_W, WIN, PIX_W, OUT_DIM=IMG_W-WIN+1 (24), NPIX=784 and the FSM state encoding in shared package cnn_pkg.
REQ-023 SHALL instantiate one sub-module, cnn_frame_buf: 784x8 storage with one write port and one combinational 25-pixel window read port addressed by (X,Y).

Verification
REQ-024 Ramp load with pixel(r,c)=(r*28+c) mod 256 -> START single pulse 1 cycle after the 784th accept. First SWEEP cycle X=0, Y=0, IMGIN[199:192]=0x00, IMGIN[7:0]=0x74. Window (23,23): IMGIN[199:192]=0x9B, IMGIN[7:0]=0x0F.
REQ-025 Sweep order check -> sweep cycle 24 is (0,23), cycle 25 is (1,0), cycle 576 is (23,23). WIN_VALID high exactly 576 cycles; then BUSY stays 1.
REQ-026 DONE=1 during SWEEP, then DONE=1 with OUT=7 in WAIT -> no effect during sweep. RES_VALID one cycle, RES_LABEL=7, PIX_READY=1 next cycle.
REQ-027 Load with PIX_VALID toggling every other cycle, plus PIX_VALID held during SWEEP -> same windows as REQ-024; no buffer writes outside LOAD.
REQ-028 nRST=0 at sweep window (10,5) -> next cycle all outputs at reset values. A full reload followed by a sweep then reproduces REQ-024 values.
